// File: rtl/io_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : io_input_conditioner
// Description : Synchronises and debounces the 24 board switches (as a single
//               word) and the confirm push-button. Outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module io_input_conditioner #(
    parameter int DB_CYCLES = 1000,
    parameter int CNT_W     = 20
) (
    input  logic        clk,
    input  logic        fpga_rst,
    input  logic [23:0] sw_raw,
    input  logic        btn_raw,
    output logic [23:0] io_rdata,
    output logic        sw_changed,
    output logic        btn_level,
    output logic        btn_press
);

    localparam int              c_SW_W    = 24;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Two-stage synchronisers
    logic [c_SW_W-1:0] r_sw_s1;
    logic [c_SW_W-1:0] r_sw_s2;
    logic              r_btn_s1;
    logic              r_btn_s2;

    // Switch-word debounce channel
    logic [c_SW_W-1:0] r_sw_cand;
    logic [CNT_W-1:0]  r_sw_cnt;
    logic [c_SW_W-1:0] r_sw_out;
    logic              r_sw_chg;
    logic              w_sw_diff;
    logic              w_sw_update;
    logic [CNT_W-1:0]  w_sw_cnt_nxt;

    // Button debounce channel
    logic              r_btn_cand;
    logic [CNT_W-1:0]  r_btn_cnt;
    logic              r_btn_out;
    logic              r_btn_press;
    logic              w_btn_diff;
    logic              w_btn_update;
    logic [CNT_W-1:0]  w_btn_cnt_nxt;

    // ------------------------------------------------------------------
    // Switch channel: any bit difference restarts the whole word's count
    // ------------------------------------------------------------------
    assign w_sw_diff   = (r_sw_s2 != r_sw_cand);
    assign w_sw_update = !w_sw_diff && (r_sw_cnt == c_CNT_MAX) && (r_sw_cand != r_sw_out);

    always_comb begin
        w_sw_cnt_nxt = r_sw_cnt;
        if (w_sw_diff) begin
            w_sw_cnt_nxt = '0;
        end else if (r_sw_cnt < c_CNT_MAX) begin
            w_sw_cnt_nxt = r_sw_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Button channel
    // ------------------------------------------------------------------
    assign w_btn_diff   = (r_btn_s2 != r_btn_cand);
    assign w_btn_update = !w_btn_diff && (r_btn_cnt == c_CNT_MAX) && (r_btn_cand != r_btn_out);

    always_comb begin
        w_btn_cnt_nxt = r_btn_cnt;
        if (w_btn_diff) begin
            w_btn_cnt_nxt = '0;
        end else if (r_btn_cnt < c_CNT_MAX) begin
            w_btn_cnt_nxt = r_btn_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_sw_cand <= '0;
            r_sw_cnt  <= '0;
            r_sw_out  <= '0;
            r_sw_chg  <= 1'b0;
        end else begin
            r_sw_s1  <= sw_raw;
            r_sw_s2  <= r_sw_s1;
            r_sw_cnt <= w_sw_cnt_nxt;
            if (w_sw_diff) begin
                r_sw_cand <= r_sw_s2;
            end
            if (w_sw_update) begin
                r_sw_out <= r_sw_cand;
            end
            r_sw_chg <= w_sw_update;
        end
    end

    always_ff @(posedge clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_btn_cand  <= 1'b0;
            r_btn_cnt   <= '0;
            r_btn_out   <= 1'b0;
            r_btn_press <= 1'b0;
        end else begin
            r_btn_s1  <= btn_raw;
            r_btn_s2  <= r_btn_s1;
            r_btn_cnt <= w_btn_cnt_nxt;
            if (w_btn_diff) begin
                r_btn_cand <= r_btn_s2;
            end
            if (w_btn_update) begin
                r_btn_out <= r_btn_cand;
            end
            // Pulse only when the accepted level is a rise
            r_btn_press <= w_btn_update & r_btn_cand;
        end
    end

    assign io_rdata   = r_sw_out;
    assign sw_changed = r_sw_chg;
    assign btn_level  = r_btn_out;
    assign btn_press  = r_btn_press;

endmodule
`default_nettype wire

// File: tb/tb_io_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_input_conditioner
// Description : Directed scoreboard bench for io_input_conditioner (DB=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_input_conditioner;

    localparam int c_DB  = 8;
    localparam int c_LAT = c_DB + 3;

    logic        clk;
    logic        fpga_rst;
    logic [23:0] sw_raw;
    logic        btn_raw;
    logic [23:0] io_rdata;
    logic        sw_changed;
    logic        btn_level;
    logic        btn_press;

    typedef struct {
        int          cyc;
        logic [23:0] val;
    } sw_ev_t;

    typedef struct {
        int   cyc;
        logic lvl;
    } btn_ev_t;

    sw_ev_t  swq[$];
    btn_ev_t btnq[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [23:0] exp_io  = '0;
    logic        exp_swp = 1'b0;
    logic        exp_lvl = 1'b0;
    logic        exp_bp  = 1'b0;

    io_input_conditioner #(
        .DB_CYCLES (c_DB),
        .CNT_W     (20)
    ) dut (
        .clk        (clk),
        .fpga_rst   (fpga_rst),
        .sw_raw     (sw_raw),
        .btn_raw    (btn_raw),
        .io_rdata   (io_rdata),
        .sw_changed (sw_changed),
        .btn_level  (btn_level),
        .btn_press  (btn_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_sw(input logic [23:0] v);
        sw_ev_t e;
        e.cyc = cyc + c_LAT;
        e.val = v;
        swq.push_back(e);
    endtask

    task automatic push_btn(input logic l);
        btn_ev_t e;
        e.cyc = cyc + c_LAT;
        e.lvl = l;
        btnq.push_back(e);
    endtask

    // One clock: sample on the falling edge and score every output
    task automatic tick();
        @(negedge clk);
        cyc++;
        exp_swp = 1'b0;
        exp_bp  = 1'b0;
        if (swq.size() > 0 && swq[0].cyc == cyc) begin
            exp_swp = (swq[0].val != exp_io);
            exp_io  = swq[0].val;
            void'(swq.pop_front());
        end
        if (btnq.size() > 0 && btnq[0].cyc == cyc) begin
            exp_bp  = btnq[0].lvl & ~exp_lvl;
            exp_lvl = btnq[0].lvl;
            void'(btnq.pop_front());
        end
        chk("sw_changed", {31'd0, sw_changed}, {31'd0, exp_swp});
        chk("io_rdata",   {8'd0, io_rdata},    {8'd0, exp_io});
        chk("btn_press",  {31'd0, btn_press},  {31'd0, exp_bp});
        chk("btn_level",  {31'd0, btn_level},  {31'd0, exp_lvl});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic assert_reset();
        fpga_rst = 1'b1;
        swq.delete();
        btnq.delete();
        exp_io  = '0;
        exp_lvl = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fpga_rst = 1'b1;
        sw_raw   = '0;
        btn_raw  = 1'b0;
        assert_reset();
        ticks(5);

        // Release with all-zero inputs: no pulses at all
        fpga_rst = 1'b0;
        ticks(15);

        // Long reset, then a switch word arriving with release
        assert_reset();
        ticks(20);
        fpga_rst = 1'b0;
        sw_raw   = 24'h0A0078;
        push_sw(24'h0A0078);
        ticks(20);

        // Fresh start, then a 5-cycle toggle on bit 0 must never be accepted
        assert_reset();
        sw_raw = '0;
        ticks(3);
        fpga_rst = 1'b0;
        ticks(12);
        for (int seg = 0; seg < 12; seg++) begin
            sw_raw = (seg % 2 == 0) ? 24'h000001 : 24'h000000;
            ticks(5);
        end
        ticks(15);

        // Button rise held 20 cycles, then fall
        btn_raw = 1'b1;
        push_btn(1'b1);
        ticks(20);
        btn_raw = 1'b0;
        push_btn(1'b0);
        ticks(15);

        // Simultaneous switch and button events
        sw_raw  = 24'hEF0000;
        btn_raw = 1'b1;
        push_sw(24'hEF0000);
        push_btn(1'b1);
        ticks(15);

        // Reset mid-count: outputs clear at once, full latency after release
        sw_raw = 24'h123456;
        ticks(5);
        assert_reset();
        #1;
        chk("async_io_rdata",  {8'd0, io_rdata},   32'd0);
        chk("async_btn_level", {31'd0, btn_level}, 32'd0);
        ticks(2);
        fpga_rst = 1'b0;
        push_sw(24'h123456);
        push_btn(1'b1);
        ticks(15);

        // Bounce of DB_CYCLES-1 cycles on one bit is rejected
        sw_raw = 24'h923456;
        ticks(c_DB - 1);
        sw_raw = 24'h123456;
        ticks(15);

        // Long hold: counters saturate, no further pulses
        ticks(100);
        chk("sw_cnt_sat",  32'(dut.r_sw_cnt),  32'd7);
        chk("btn_cnt_sat", 32'(dut.r_btn_cnt), 32'd7);
        chk("sw_queue_empty",  32'(swq.size()),  32'd0);
        chk("btn_queue_empty", 32'(btnq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_input_conditioner.md
IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000, meaning the number of consecutive cycles an input must hold unchanged before it is accepted; legal range 2..2^CNT_W.
REQ-002 SHALL have parameter CNT_W, default 20, meaning the debounce counter width.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state is on its rising edge.
REQ-004 SHALL have port fpga_rst, input, 1, meaning the asynchronous active-high reset.
REQ-005 SHALL have port sw_raw, input, 24, meaning the unsynchronised board switch levels.
REQ-006 SHALL have port btn_raw, input, 1, meaning the unsynchronised confirm push-button level.
REQ-007 SHALL have port io_rdata, output, 24, meaning the debounced switch word presented to the CPU IO read path.
REQ-008 SHALL have port sw_changed, output, 1, meaning a one-cycle pulse asserted in the cycle io_rdata takes a new value.
REQ-009 SHALL have port btn_level, output, 1, meaning the debounced button level.
REQ-010 SHALL have port btn_press, output, 1, meaning a one-cycle pulse asserted on the 0->1 transition of btn_level.

Function
REQ-011 SHALL pass sw_raw and btn_raw through two flip-flop synchroniser stages (s1, s2) each before any other use.
REQ-012 SHALL hold, per channel (switch word, button), a candidate register and a CNT_W-bit counter; all outputs are registered.
REQ-013 SHALL, each cycle a channel's s2 differs from its candidate: load candidate <= s2 and clear counter to 0.
REQ-014 SHALL, when s2 equals the candidate and counter < DB_CYCLES-1: increment counter by 1.
REQ-015 SHALL, when s2 equals the candidate and counter == DB_CYCLES-1: hold the counter (saturate; no wrap-around), and load the channel output with the candidate if they differ.
REQ-016 SHALL assert sw_changed high for exactly one cycle, coincident with the edge that updates io_rdata; no pulse when the accepted value equals the current io_rdata.
REQ-017 SHALL make an sw_raw change, held stable from before rising edge 1, appear on io_rdata at rising edge DB_CYCLES+3 (2 synchroniser edges, 1 candidate edge, DB_CYCLES-1 count edges, 1 update edge).
REQ-018 SHALL give the button channel the same latency as REQ-017, with btn_press asserted in the same cycle btn_level rises and never on a fall.
REQ-019 SHALL ignore any input glitch or bounce shorter than DB_CYCLES cycles at s2; each bounce restarts the count.
REQ-020 SHALL treat the 24 switch bits as one word: a change on any bit restarts the word's count, and all bits update together.
REQ-021 SHALL run the switch and button channels fully independently; simultaneous events on both SHALL each produce their own pulses in the same cycle.

Reset
REQ-022 SHALL, while fpga_rst is high, asynchronously clear s1, s2, candidates, counters, io_rdata, sw_changed, btn_level and btn_press to 0.
REQ-023 SHALL, on reset asserted mid-count, discard the partial count, so that after release a nonzero input needs the full DB_CYCLES+3 edges to appear.
REQ-024 SHALL produce no sw_changed or btn_press pulse on the first cycles after reset release when the inputs are all zero.

Verification (DB_CYCLES=8)
REQ-025 SHALL cover: reset 20 cycles, release, then sw_raw=24'h0A0078 stable -> io_rdata=24'h0A0078 and a single sw_changed pulse at edge 11; no change before.
REQ-026 SHALL cover: sw_raw toggling between 24'h000001 and 24'h000000 every 5 cycles for 60 cycles -> io_rdata stays 0 and sw_changed is never asserted.
REQ-027 SHALL cover: btn_raw 0->1 held 20 cycles, then 1->0 -> a single btn_press pulse at edge 11 after the rise; btn_level is 0 again at edge 11 after the fall, with no pulse.
REQ-028 SHALL cover: sw_raw=24'hEF0000 and btn_raw=1 changing in the same cycle -> sw_changed and btn_press are asserted in the same cycle.
REQ-029 SHALL cover: fpga_rst asserted 3 cycles into a count and then released, with the input held -> outputs clear immediately, and the update occurs 11 edges after release.
REQ-030 SHALL cover: input held 100 cycles after acceptance -> the counter stays at 7 and no further pulses occur.
